pwm_multi_chan: RTL

Multi-channel PWM generator: one shared period counter drives NUM_CH independent duty comparators. Each channel has its own duty, polarity and enable, and all channels share an 8-bit brightness scale. Settings are double-buffered and applied only at a period boundary, so updates never glitch. Edge-aligned and center-aligned counting are both supported; it is the drop-in successor to the single-channel pwm_module for LED/motor banks.

---
 rtl/pwm_multi_chan.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pwm_multi_chan.sv
`timescale 1ns/1ps
// pwm_multi_chan: one shared period counter feeding NUM_CH duty comparators.
// All settings are double-buffered and only change on a period boundary.
module pwm_multi_chan #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
) (
    input  logic                    i_sysclk,
    input  logic                    i_resetn,
    input  logic                    i_enable,
    input  logic                    i_center,
    input  logic [CNT_W-1:0]        i_freq_cnt,
    input  logic [NUM_CH*CNT_W-1:0] i_duty_cnt,
    input  logic [NUM_CH-1:0]       i_polar,
    input  logic [NUM_CH-1:0]       i_ch_en,
    input  logic [7:0]              i_brightness,
    input  logic                    i_update,
    output logic                    o_update_ack,
    output logic                    o_period_tick,
    output logic [NUM_CH-1:0]       o_pwm_out
);

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

    // Update handshake: i_update is a one-cycle request with no ready; requests
    // before a boundary merge, the inputs present at the boundary are taken, and
    // o_update_ack pulses once in the cycle after that boundary. Never while stopped.

    logic [CNT_W-1:0]        p_q;
    logic [NUM_CH*CNT_W-1:0] d_q;
    logic [NUM_CH-1:0]       polar_q;
    logic [NUM_CH-1:0]       ch_en_q;
    logic                    center_q;
    logic [7:0]              b_q;

    logic [CNT_W-1:0]        cnt_q;
    dir_e                    dir_q;
    logic                    pending_q;

    logic [NUM_CH-1:0]       pwm_q;
    logic                    tick_q;
    logic                    ack_q;

    logic                    short_period;
    logic [CNT_W-1:0]        p_last;
    logic                    at_top;
    logic                    boundary;
    logic                    apply;
    logic                    load_active;
    logic                    tick_next;
    logic [8:0]              b_plus;
    logic [NUM_CH-1:0]       raw;
    logic [NUM_CH-1:0]       pwm_next;

    // Periods of 0 or 1 count have no usable counter range: hold cnt at 0.
    assign short_period = (p_q < CNT_W'(2));
    assign p_last       = p_q - CNT_W'(1);
    assign at_top       = (cnt_q >= p_last);
    assign boundary     = !short_period &&
                          (center_q ? ((dir_q == DIR_DOWN) && (cnt_q == '0)) : at_top);
    assign apply        = i_enable && boundary && (pending_q || i_update);
    assign load_active  = !i_enable || apply;
    assign tick_next    = !short_period && (dir_q == DIR_UP) && (cnt_q == '0);
    assign b_plus       = {1'b0, b_q} + 9'd1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [CNT_W+7:0] prod;
        logic [CNT_W-1:0] eff;

        // D*(B+1) always fits in CNT_W+8 bits; the >>8 brings it back to CNT_W.
        assign prod        = (CNT_W+8)'(d_q[k*CNT_W +: CNT_W]) * (CNT_W+8)'(b_plus);
        assign eff         = CNT_W'(prod >> 8);
        assign raw[k]      = short_period ? (eff != '0) : (cnt_q < eff);
        assign pwm_next[k] = ch_en_q[k] ? (raw[k] ^ polar_q[k]) : polar_q[k];
    end

    always_ff @(posedge i_sysclk or negedge i_resetn) begin
        if (!i_resetn) begin
            p_q      <= '0;
            d_q      <= '0;
            polar_q  <= '0;
            ch_en_q  <= '0;
            center_q <= 1'b0;
            b_q      <= '0;
        end else if (load_active) begin
            p_q      <= i_freq_cnt;
            d_q      <= i_duty_cnt;
            polar_q  <= i_polar;
            ch_en_q  <= i_ch_en;
            center_q <= i_center;
            b_q      <= i_brightness;
        end
    end

    always_ff @(posedge i_sysclk or negedge i_resetn) begin
        if (!i_resetn) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            pending_q <= 1'b0;
        end else if (!i_enable) begin
            cnt_q     <= '0;
            dir_q     <= DIR_UP;
            pending_q <= 1'b0;
        end else begin
            pending_q <= boundary ? 1'b0 : (pending_q | i_update);
            if (short_period || boundary) begin
                cnt_q <= '0;
                dir_q <= DIR_UP;
            end else if (!center_q) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (dir_q == DIR_UP) begin
                // Center mode visits P-1 twice: last up count, then first down count.
                if (at_top) dir_q <= DIR_DOWN;
                else        cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_sysclk or negedge i_resetn) begin
        if (!i_resetn) begin
            pwm_q  <= '0;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
        end else if (!i_enable) begin
            pwm_q  <= i_polar;
            tick_q <= 1'b0;
            ack_q  <= 1'b0;
        end else begin
            pwm_q  <= pwm_next;
            tick_q <= tick_next;
            ack_q  <= apply;
        end
    end

    assign o_pwm_out     = pwm_q;
    assign o_period_tick = tick_q;
    assign o_update_ack  = ack_q;

endmodule
